flits_sender: RTL and testbench
===============================

FLITS_SENDER -- requirements
Module: flits_sender

Interface
REQ-001 The module SHALL have parameter FLIT_WIDTH, default 64, flit width in bits.
REQ-002 The module SHALL have parameter MAX_PACKET_LENGHT, default 8, maximum flits per packet.
REQ-003 The module SHALL have parameter N_CREDITS, default 4, flit slots in the downstream flits buffer.
REQ-004 The module SHALL have parameter N_BITS_LEN, default clog2(MAX_PACKET_LENGHT+1), width of the length field.
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-007 The module SHALL have port pkt_i, input, MAX_PACKET_LENGHT*FLIT_WIDTH, the packet; flit k in bits [(k+1)*FLIT_WIDTH-1 : k*FLIT_WIDTH].
REQ-008 The module SHALL have port pkt_len_i, input, N_BITS_LEN, the number of flits in the packet.
REQ-009 The module SHALL have port pkt_valid_i, input, 1, the packet offer.
REQ-010 The module SHALL have port pkt_ready_o, output, 1, packet acceptance.
REQ-011 The module SHALL have port out_link_o, output, FLIT_WIDTH, the flit toward the link.
REQ-012 The module SHALL have port is_valid_o, output, 1, out_link_o carries a flit this cycle.
REQ-013 The module SHALL have port credit_i, input, 1, a one-cycle pulse; one downstream slot freed.
REQ-014 The module SHALL have port credit_cnt_o, output, clog2(N_CREDITS+1), current credits.
REQ-015 The module SHALL have port credit_err_o, output, 1, sticky credit-overflow flag.

Function
REQ-016 The FSM SHALL have states IDLE and SEND; pkt_ready_o SHALL be 1 exactly in IDLE.
REQ-017 Handshake: pkt_valid_i and pkt_ready_o high at a rising edge SHALL latch pkt_i and the effective length, zero flit index, and enter SEND.
REQ-018 Effective length SHALL be 1 for pkt_len_i=0, MAX_PACKET_LENGHT for pkt_len_i>MAX_PACKET_LENGHT, and pkt_len_i otherwise.
REQ-019 In SEND with credit_cnt_o>0, each edge SHALL register flit[idx] on out_link_o with is_valid_o=1 and then increment idx.
REQ-020 In SEND with credit_cnt_o=0, is_valid_o SHALL be 0 next cycle, idx SHALL hold, and out_link_o SHALL hold its value.
REQ-021 Bits [1:0] of each emitted flit SHALL be forced to the flit type: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 head-tail (length 1); upper bits SHALL pass through unchanged.
REQ-022 Outside SEND, and in cycles with no emission, is_valid_o SHALL be 0.
REQ-023 Latency: if credits are available, the first flit SHALL be valid in the cycle after the accept edge; a packet of L flits SHALL then take L consecutive valid cycles.
REQ-024 The edge emitting the last flit SHALL return the FSM to IDLE, so pkt_ready_o is 1 the following cycle; back-to-back packets SHALL have exactly one idle link cycle between them.
REQ-025 The credit counter SHALL decrement by 1 on each emission and increment by 1 on credit_i; when both occur on the same edge it SHALL be unchanged.
REQ-026 A credit_i with no emission while credit_cnt_o=N_CREDITS SHALL leave the count saturated and set credit_err_o, which SHALL stay 1 until reset.
REQ-027 Changes on pkt_i, pkt_len_i or pkt_valid_i during SEND SHALL have no effect on the flits being sent.

Reset
REQ-028 While rst=0, regardless of clk: state SHALL be IDLE, pkt_ready_o=1, is_valid_o=0, out_link_o=0, idx=0, credit_cnt_o=N_CREDITS, credit_err_o=0.
REQ-029 Reset asserted mid-packet SHALL abort the packet immediately, with no further flits after release; a new packet SHALL be accepted on the first edge after release.

Verification
REQ-030 Single flit: pkt_len_i=1, flit0=64'hFF0, credits=4 -> one valid cycle with out_link_o=64'hFF3; credit_cnt_o goes 4->3; pkt_ready_o is 1 next cycle.
REQ-031 Five flits: payloads 0x00,0x10,0x20,0x30,0x70 -> five consecutive flits 0x00,0x11,0x21,0x31,0x72; with no credit_i, credit_cnt_o ends at 0 after the 4th flit and the 5th is stalled.
REQ-032 Credit stall/resume: continuing REQ-031, one credit_i pulse -> the 5th flit (0x72) is emitted next cycle; credit_cnt_o goes 0->1->0.
REQ-033 Simultaneous events: credit_i coincides with an emission at credit_cnt_o=2 -> credit_cnt_o stays 2; an extra credit_i at credit_cnt_o=4 with no emission -> count stays 4 and credit_err_o=1.
REQ-034 Length clamp and reset: pkt_len_i=0 -> one head-tail flit; pkt_len_i=12 -> 8 flits; rst=0 after the 2nd of 8 flits -> is_valid_o=0 immediately, credit_cnt_o=4, and no further flits.
REQ-035 Back-to-back: pkt_valid_i held high with two 2-flit packets -> link pattern valid,valid,idle,valid,valid.

Source files
------------

// File: rtl/flits_sender.sv
// Packet-to-flit serializer with credit-based flow control toward a downstream flit buffer.
// A packet is latched whole, then sent one flit per cycle while credits remain.
module flits_sender #(
   parameter int FLIT_WIDTH        = 64,
   parameter int MAX_PACKET_LENGHT = 8,
   parameter int N_CREDITS         = 4,
   parameter int N_BITS_LEN        = $clog2(MAX_PACKET_LENGHT + 1)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_i,
   input  logic [N_BITS_LEN-1:0]                   pkt_len_i,
   input  logic                                    pkt_valid_i,
   output logic                                    pkt_ready_o,
   output logic [FLIT_WIDTH-1:0]                   out_link_o,
   output logic                                    is_valid_o,
   input  logic                                    credit_i,
   output logic [$clog2(N_CREDITS+1)-1:0]          credit_cnt_o,
   output logic                                    credit_err_o,
   output logic                                    dbg_state
);

   localparam int CW = $clog2(N_CREDITS + 1);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                                  state;
   logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_q;
   logic [N_BITS_LEN-1:0]                   len_q;
   logic [N_BITS_LEN-1:0]                   idx;

   logic                  emit;
   logic                  last;
   logic [1:0]            ftype;
   logic [FLIT_WIDTH-1:0] flit_raw;
   logic [N_BITS_LEN-1:0] eff_len;

   always_comb begin
      emit     = (state == SEND) && (credit_cnt_o != '0);
      last     = (idx == len_q - N_BITS_LEN'(1));
      flit_raw = pkt_q[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH];
      // Type code overwrites the two LSBs of the payload flit
      if (len_q == N_BITS_LEN'(1))
         ftype = 2'b11;
      else if (idx == '0)
         ftype = 2'b00;
      else if (last)
         ftype = 2'b10;
      else
         ftype = 2'b01;
      // Zero-length offers become single flits; oversized ones are truncated
      if (pkt_len_i == '0)
         eff_len = N_BITS_LEN'(1);
      else if (pkt_len_i > N_BITS_LEN'(MAX_PACKET_LENGHT))
         eff_len = N_BITS_LEN'(MAX_PACKET_LENGHT);
      else
         eff_len = pkt_len_i;
   end

   assign pkt_ready_o = (state == IDLE);
   assign dbg_state   = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pkt_q        <= '0;
         len_q        <= N_BITS_LEN'(1);
         idx          <= '0;
         out_link_o   <= '0;
         is_valid_o   <= 1'b0;
         credit_cnt_o <= CW'(N_CREDITS);
         credit_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_valid_i) begin
                  pkt_q <= pkt_i;
                  len_q <= eff_len;
                  idx   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (emit) begin
                  idx <= idx + N_BITS_LEN'(1);
                  if (last)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         is_valid_o <= emit;
         if (emit)
            out_link_o <= {flit_raw[FLIT_WIDTH-1:2], ftype};

         // Simultaneous emission and returned credit cancel out
         if (emit && !credit_i)
            credit_cnt_o <= credit_cnt_o - CW'(1);
         else if (!emit && credit_i) begin
            if (credit_cnt_o == CW'(N_CREDITS))
               credit_err_o <= 1'b1;
            else
               credit_cnt_o <= credit_cnt_o + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_flits_sender.sv
// Directed bench for flits_sender: single flit, credit stall/resume, credit corner cases,
// length clamping, mid-packet reset and back-to-back packets.
module tb_flits_sender;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] pkt;
   logic [3:0]   pkt_len;
   logic         pkt_valid;
   logic         pkt_ready;
   logic [63:0]  out_link;
   logic         is_valid;
   logic         credit;
   logic [2:0]   credit_cnt;
   logic         credit_err;
   logic         dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   flits_sender dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_i        (pkt),
      .pkt_len_i    (pkt_len),
      .pkt_valid_i  (pkt_valid),
      .pkt_ready_o  (pkt_ready),
      .out_link_o   (out_link),
      .is_valid_o   (is_valid),
      .credit_i     (credit),
      .credit_cnt_o (credit_cnt),
      .credit_err_o (credit_err),
      .dbg_state    (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks the link-side outputs in one call
   task automatic chk_link(input string tag, input logic v, input logic [63:0] data,
                           input logic [2:0] cnt, input logic rdy);
      chk({tag, ".valid"}, 64'(is_valid), 64'(v));
      if (v) chk({tag, ".data"}, out_link, data);
      chk({tag, ".cnt"}, 64'(credit_cnt), 64'(cnt));
      chk({tag, ".ready"}, 64'(pkt_ready), 64'(rdy));
   endtask

   task automatic credit_pulse();
      credit = 1'b1;
      tick();
      credit = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      pkt       = '0;
      pkt_len   = '0;
      pkt_valid = 1'b0;
      credit    = 1'b0;
      #23;
      chk("rst.ready", 64'(pkt_ready), 64'd1);
      chk("rst.valid", 64'(is_valid), 64'd0);
      chk("rst.link", out_link, 64'd0);
      chk("rst.cnt", 64'(credit_cnt), 64'd4);
      chk("rst.err", 64'(credit_err), 64'd0);
      chk("rst.state", 64'(dbg_state), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Single flit
      pkt[63:0] = 64'hFF0; pkt_len = 4'd1; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
      chk_link("single.accept", 1'b0, 64'd0, 3'd4, 1'b0);
      chk("single.state", 64'(dbg_state), 64'd1);
      tick();
      chk_link("single.emit", 1'b1, 64'hFF3, 3'd3, 1'b1);
      tick();
      chk_link("single.after", 1'b0, 64'd0, 3'd3, 1'b1);
      credit_pulse();
      chk("single.refill", 64'(credit_cnt), 64'd4);

      // Five flits, stalls on the fifth
      pkt = '0;
      pkt[0*64 +: 64] = 64'h00; pkt[1*64 +: 64] = 64'h10; pkt[2*64 +: 64] = 64'h20;
      pkt[3*64 +: 64] = 64'h30; pkt[4*64 +: 64] = 64'h70;
      pkt_len = 4'd5; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0; pkt = {8{64'hDEAD_BEEF_0000_0F00}}; pkt_len = 4'd2;
      tick(); chk_link("five.f0", 1'b1, 64'h00, 3'd3, 1'b0);
      tick(); chk_link("five.f1", 1'b1, 64'h11, 3'd2, 1'b0);
      tick(); chk_link("five.f2", 1'b1, 64'h21, 3'd1, 1'b0);
      tick(); chk_link("five.f3", 1'b1, 64'h31, 3'd0, 1'b0);
      tick(); chk_link("five.stall", 1'b0, 64'd0, 3'd0, 1'b0);
      chk("five.hold", out_link, 64'h31);
      tick(); chk_link("five.stall2", 1'b0, 64'd0, 3'd0, 1'b0);
      credit_pulse();
      chk_link("five.credit", 1'b0, 64'd0, 3'd1, 1'b0);
      tick(); chk_link("five.f4", 1'b1, 64'h72, 3'd0, 1'b1);
      tick(); chk_link("five.idle", 1'b0, 64'd0, 3'd0, 1'b1);

      // Credit returned on the same edge as an emission
      credit_pulse(); credit_pulse();
      chk("simul.cnt2", 64'(credit_cnt), 64'd2);
      pkt = '0;
      pkt[0*64 +: 64] = 64'hA0; pkt[1*64 +: 64] = 64'hB0; pkt[2*64 +: 64] = 64'hC0;
      pkt_len = 4'd3; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0; credit = 1'b1;
      tick();
      credit = 1'b0;
      chk_link("simul.f0", 1'b1, 64'hA0, 3'd2, 1'b0);
      tick(); chk_link("simul.f1", 1'b1, 64'hB1, 3'd1, 1'b0);
      tick(); chk_link("simul.f2", 1'b1, 64'hC2, 3'd0, 1'b1);
      credit_pulse(); credit_pulse(); credit_pulse(); credit_pulse();
      chk("ovf.full", 64'(credit_cnt), 64'd4);
      chk("ovf.noerr", 64'(credit_err), 64'd0);
      credit_pulse();
      chk("ovf.sat", 64'(credit_cnt), 64'd4);
      chk("ovf.err", 64'(credit_err), 64'd1);
      tick(); tick();
      chk("ovf.sticky", 64'(credit_err), 64'd1);

      // Zero length becomes a single head-tail flit
      pkt = '0; pkt[63:0] = 64'h5554; pkt_len = 4'd0; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
      tick(); chk_link("len0.emit", 1'b1, 64'h5557, 3'd3, 1'b1);
      tick(); chk_link("len0.after", 1'b0, 64'd0, 3'd3, 1'b1);
      credit_pulse();

      // Length 12 clamps to 8, credits returned every cycle
      for (int k = 0; k < 8; k++) pkt[k*64 +: 64] = 64'(256 * (k + 1));
      pkt_len = 4'd12; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0; credit = 1'b1;
      tick(); chk_link("clamp.f0", 1'b1, 64'h100, 3'd4, 1'b0);
      for (int k = 1; k < 7; k++) begin
         tick(); chk_link($sformatf("clamp.f%0d", k), 1'b1, 64'(256 * (k + 1) + 1), 3'd4, 1'b0);
      end
      tick(); chk_link("clamp.f7", 1'b1, 64'h802, 3'd4, 1'b1);
      credit = 1'b0;
      tick(); chk_link("clamp.idle", 1'b0, 64'd0, 3'd4, 1'b1);

      // Reset in the middle of an 8-flit packet
      pkt_len = 4'd8; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0; credit = 1'b1;
      tick(); chk_link("abort.f0", 1'b1, 64'h100, 3'd4, 1'b0);
      tick(); chk_link("abort.f1", 1'b1, 64'h201, 3'd4, 1'b0);
      credit = 1'b0;
      rst = 1'b0;
      #1;
      chk("abort.valid", 64'(is_valid), 64'd0);
      chk("abort.cnt", 64'(credit_cnt), 64'd4);
      chk("abort.ready", 64'(pkt_ready), 64'd1);
      chk("abort.link", out_link, 64'd0);
      chk("abort.err", 64'(credit_err), 64'd0);
      tick();
      rst = 1'b1;
      tick(); chk_link("abort.quiet0", 1'b0, 64'd0, 3'd4, 1'b1);
      tick(); chk_link("abort.quiet1", 1'b0, 64'd0, 3'd4, 1'b1);

      // Back-to-back two-flit packets with valid held high
      pkt = '0; pkt[0*64 +: 64] = 64'h40; pkt[1*64 +: 64] = 64'h50;
      pkt_len = 4'd2; pkt_valid = 1'b1;
      tick(); chk_link("b2b.accept", 1'b0, 64'd0, 3'd4, 1'b0);
      tick(); chk_link("b2b.p0f0", 1'b1, 64'h40, 3'd3, 1'b0);
      tick(); chk_link("b2b.p0f1", 1'b1, 64'h52, 3'd2, 1'b1);
      tick(); chk_link("b2b.gap", 1'b0, 64'd0, 3'd2, 1'b0);
      pkt_valid = 1'b0;
      tick(); chk_link("b2b.p1f0", 1'b1, 64'h40, 3'd1, 1'b0);
      tick(); chk_link("b2b.p1f1", 1'b1, 64'h52, 3'd0, 1'b1);
      tick(); chk_link("b2b.end", 1'b0, 64'd0, 3'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
